// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_writeback
//  Purpose  : Register-file write-back arbiter. Merges in-order load returns
//             (tracked by a 4-deep load-tag FIFO) with ALU results buffered
//             through a one-entry skid register, and drives a registered
//             register-file write port. Loads always win the write port.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_dest,
  input  logic [31:0] i_alu_data,
  output logic        o_alu_ready,
  input  logic        i_mem_req_valid,
  input  logic [4:0]  i_mem_req_dest,
  input  logic        i_mem_resp_valid,
  input  logic [31:0] i_mem_resp_data,
  output logic        o_reg_we,
  output logic [4:0]  o_reg_waddr,
  output logic [31:0] o_reg_wdata,
  output logic [31:0] o_pending,
  output logic        o_load_full,
  output logic        o_protocol_err
);

  localparam logic [2:0] c_DEPTH    = 3'd4;
  localparam logic       c_ST_EMPTY = 1'b0;
  localparam logic       c_ST_HELD  = 1'b1;

  // Load-tag FIFO state
  logic [4:0]  r_tag [0:3];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;

  // Skid state
  logic        r_state;
  logic        w_state_nxt;
  logic [4:0]  r_skid_dest;
  logic [31:0] r_skid_data;

  // Write-port registers and sticky error
  logic        r_reg_we;
  logic [4:0]  r_reg_waddr;
  logic [31:0] r_reg_wdata;
  logic        r_protocol_err;

  // Combinational control
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic [4:0]  w_head;
  logic        w_alu_acc;
  logic        w_skid_load;
  logic        w_wr_valid;
  logic [4:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic [1:0]  w_off;
  logic [31:0] w_pending;

  // FIFO handshake: a pop frees a slot in the same cycle, so a full FIFO can still push
  always_comb begin
    w_full    = (r_count == c_DEPTH);
    w_pop     = i_mem_resp_valid && (r_count != 3'd0);
    w_push    = i_mem_req_valid && (!w_full || w_pop);
    w_head    = r_tag[r_rptr];
    w_alu_acc = i_alu_valid && o_alu_ready;
  end

  // Load-tag FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_tag[i] <= 5'd0;
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) begin
        r_tag[r_wptr] <= i_mem_req_dest;
        r_wptr        <= r_wptr + 2'd1;
      end
      if (w_pop) r_rptr <= r_rptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky protocol error: dropped push on full FIFO or response with nothing outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_protocol_err <= 1'b0;
    end else if ((i_mem_req_valid && !w_push) || (i_mem_resp_valid && (r_count == 3'd0))) begin
      r_protocol_err <= 1'b1;
    end
  end

  // Skid state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Skid next state: fill when an accepted ALU result loses to a load, drain when the port is free
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_EMPTY: if (w_alu_acc && w_pop) w_state_nxt = c_ST_HELD;
      c_ST_HELD:  if (!w_pop)             w_state_nxt = c_ST_EMPTY;
      default:    w_state_nxt = c_ST_EMPTY;
    endcase
  end

  // Skid outputs: ready depends on state only, never on this cycle's inputs
  always_comb begin
    o_alu_ready = (r_state == c_ST_EMPTY);
    w_skid_load = (r_state == c_ST_EMPTY) && w_alu_acc && w_pop;
  end

  // Skid payload capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_dest <= 5'd0;
      r_skid_data <= 32'd0;
    end else if (w_skid_load) begin
      r_skid_dest <= i_alu_dest;
      r_skid_data <= i_alu_data;
    end
  end

  // Write-port source select: load response, then held skid entry, then direct ALU
  always_comb begin
    w_wr_valid = 1'b0;
    w_wr_addr  = 5'd0;
    w_wr_data  = 32'd0;
    if (w_pop) begin
      w_wr_valid = 1'b1;
      w_wr_addr  = w_head;
      w_wr_data  = i_mem_resp_data;
    end else if (r_state == c_ST_HELD) begin
      w_wr_valid = 1'b1;
      w_wr_addr  = r_skid_dest;
      w_wr_data  = r_skid_data;
    end else if (w_alu_acc) begin
      w_wr_valid = 1'b1;
      w_wr_addr  = i_alu_dest;
      w_wr_data  = i_alu_data;
    end
  end

  // Registered write port; register 0 consumes the source but never asserts write enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_we    <= 1'b0;
      r_reg_waddr <= 5'd0;
      r_reg_wdata <= 32'd0;
    end else if (w_wr_valid) begin
      r_reg_we    <= (w_wr_addr != 5'd0);
      r_reg_waddr <= w_wr_addr;
      r_reg_wdata <= w_wr_data;
    end else begin
      r_reg_we    <= 1'b0;
    end
  end

  // Pending mask: a slot is live when its distance from the read pointer is below the count
  always_comb begin
    w_pending = 32'd0;
    w_off     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_off = 2'(i) - r_rptr;
      if ({1'b0, w_off} < r_count) w_pending[r_tag[i]] = 1'b1;
    end
    w_pending[0] = 1'b0;
  end

  assign o_pending      = w_pending;
  assign o_load_full    = w_full;
  assign o_reg_we       = r_reg_we;
  assign o_reg_waddr    = r_reg_waddr;
  assign o_reg_wdata    = r_reg_wdata;
  assign o_protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_writeback
//  Purpose  : Self-checking bench for regfile_writeback: table of per-cycle
//             vectors with a write-port scoreboard, plus reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_req_valid;
  logic [4:0]  mem_req_dest;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [31:0] pending;
  logic        load_full;
  logic        protocol_err;

  int errors = 0;
  int checks = 0;

  regfile_writeback dut (
    .clk              (clk),
    .rst              (rst),
    .i_alu_valid      (alu_valid),
    .i_alu_dest       (alu_dest),
    .i_alu_data       (alu_data),
    .o_alu_ready      (alu_ready),
    .i_mem_req_valid  (mem_req_valid),
    .i_mem_req_dest   (mem_req_dest),
    .i_mem_resp_valid (mem_resp_valid),
    .i_mem_resp_data  (mem_resp_data),
    .o_reg_we         (reg_we),
    .o_reg_waddr      (reg_waddr),
    .o_reg_wdata      (reg_wdata),
    .o_pending        (pending),
    .o_load_full      (load_full),
    .o_protocol_err   (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;   logic [4:0] ad;  logic [31:0] adata;
    logic        qv;   logic [4:0] qd;
    logic        rv;   logic [31:0] rdata;
    logic        ewe;  logic [4:0] ea;  logic [31:0] ed;
    logic        erdy; logic [31:0] epend; logic efull; logic eerr;
  } vec_t;

  typedef struct { logic we; logic [4:0] a; logic [31:0] d; } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];

  function automatic vec_t mk(input logic av, input logic [4:0] ad, input logic [31:0] adata,
                              input logic qv, input logic [4:0] qd,
                              input logic rv, input logic [31:0] rdata,
                              input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                              input logic erdy, input logic [31:0] epend,
                              input logic efull, input logic eerr);
    vec_t v;
    v.av = av; v.ad = ad; v.adata = adata; v.qv = qv; v.qd = qd; v.rv = rv; v.rdata = rdata;
    v.ewe = ewe; v.ea = ea; v.ed = ed; v.erdy = erdy; v.epend = epend; v.efull = efull; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and return #1 after the edge
  task automatic apply(input vec_t v);
    alu_valid = v.av; alu_dest = v.ad; alu_data = v.adata;
    mem_req_valid = v.qv; mem_req_dest = v.qd;
    mem_resp_valid = v.rv; mem_resp_data = v.rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(mk(0,0,0, 0,0, 0,0, 0,0,0, 1,0,0,0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_t e;
    // ---------------- reset state (no clock edge yet) ----------------
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    mem_req_valid = 0; mem_req_dest = 0; mem_resp_valid = 0; mem_resp_data = 0;
    rst = 1'b1;
    #2;
    chk("reset we",      32'(reg_we),       32'd0);
    chk("reset waddr",   32'(reg_waddr),    32'd0);
    chk("reset wdata",   reg_wdata,         32'd0);
    chk("reset ready",   32'(alu_ready),    32'd1);
    chk("reset pending", pending,           32'd0);
    chk("reset full",    32'(load_full),    32'd0);
    chk("reset err",     32'(protocol_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    chk("post-reset we", 32'(reg_we), 32'd0);

    // ---------------- vector table ----------------
    //            av ad  adata         qv qd  rv rdata        ewe ea  ed            rdy pend         full err
    vecs.push_back(mk(1, 5, 32'h0000F0F0, 0, 0,  0, 0,            1, 5,  32'h0000F0F0, 1, 32'h0,       0, 0)); // ALU only
    vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,            0, 0,  0,            1, 32'h0,       0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 7,  0, 0,            0, 0,  0,            1, 32'h80,      0, 0)); // load issue
    vecs.push_back(mk(0, 0, 0,            0, 0,  1, 32'hDEADBEEF, 1, 7,  32'hDEADBEEF, 1, 32'h0,       0, 0)); // load return
    vecs.push_back(mk(0, 0, 0,            1, 3,  0, 0,            0, 0,  0,            1, 32'h8,       0, 0));
    vecs.push_back(mk(1, 4, 32'h22,       0, 0,  1, 32'h11,       1, 3,  32'h11,       0, 32'h0,       0, 0)); // collision
    vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,            1, 4,  32'h22,       1, 32'h0,       0, 0)); // skid drains
    vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,            0, 0,  0,            1, 32'h0,       0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 1,  0, 0,            0, 0,  0,            1, 32'h2,       0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 2,  0, 0,            0, 0,  0,            1, 32'h6,       0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 3,  0, 0,            0, 0,  0,            1, 32'hE,       0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 4,  0, 0,            0, 0,  0,            1, 32'h1E,      1, 0)); // full
    vecs.push_back(mk(0, 0, 0,            1, 5,  0, 0,            0, 0,  0,            1, 32'h1E,      1, 1)); // overflow drop
    vecs.push_back(mk(0, 0, 0,            1, 6,  1, 32'hA1,       1, 1,  32'hA1,       1, 32'h5C,      1, 1)); // push+pop full
    vecs.push_back(mk(0, 0, 0,            0, 0,  1, 32'hA2,       1, 2,  32'hA2,       1, 32'h58,      0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0,  1, 32'hA3,       1, 3,  32'hA3,       1, 32'h50,      0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0,  1, 32'hA4,       1, 4,  32'hA4,       1, 32'h40,      0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0,  1, 32'hA6,       1, 6,  32'hA6,       1, 32'h0,       0, 1));
    vecs.push_back(mk(1, 0, 32'h55,       0, 0,  0, 0,            0, 0,  0,            1, 32'h0,       0, 1)); // ALU to r0
    vecs.push_back(mk(0, 0, 0,            1, 0,  0, 0,            0, 0,  0,            1, 32'h0,       0, 1)); // load to r0
    vecs.push_back(mk(0, 0, 0,            0, 0,  1, 32'h77,       0, 0,  0,            1, 32'h0,       0, 1));
    vecs.push_back(mk(0, 0, 0,            1, 9,  0, 0,            0, 0,  0,            1, 32'h200,     0, 1));
    vecs.push_back(mk(0, 0, 0,            1, 10, 0, 0,            0, 0,  0,            1, 32'h600,     0, 1));
    vecs.push_back(mk(1, 11, 32'hC1,      0, 0,  1, 32'hB1,       1, 9,  32'hB1,       0, 32'h400,     0, 1)); // -> HELD
    vecs.push_back(mk(1, 13, 32'hDD,      0, 0,  1, 32'hB2,       1, 10, 32'hB2,       0, 32'h0,       0, 1)); // HELD + pop
    vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,            1, 11, 32'hC1,       1, 32'h0,       0, 1)); // skid drains
    vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,            0, 0,  0,            1, 32'h0,       0, 1)); // r13 never taken

    for (int i = 0; i < vecs.size(); i++) begin
      sb.push_back('{vecs[i].ewe, vecs[i].ea, vecs[i].ed});
      apply(vecs[i]);
      if (sb.size() == 0) begin
        chk($sformatf("row%0d scoreboard", i), 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("row%0d we", i), 32'(reg_we), 32'(e.we));
        if (e.we) begin
          chk($sformatf("row%0d waddr", i), 32'(reg_waddr), 32'(e.a));
          chk($sformatf("row%0d wdata", i), reg_wdata, e.d);
        end
      end
      chk($sformatf("row%0d ready", i),   32'(alu_ready),    32'(vecs[i].erdy));
      chk($sformatf("row%0d pending", i), pending,           vecs[i].epend);
      chk($sformatf("row%0d full", i),    32'(load_full),    32'(vecs[i].efull));
      chk($sformatf("row%0d err", i),     32'(protocol_err), 32'(vecs[i].eerr));
    end
    // write port holds last address/data while idle
    chk("hold waddr", 32'(reg_waddr), 32'd11);
    chk("hold wdata", reg_wdata,      32'hC1);

    // ---------------- reset clears sticky error; empty response ----------------
    #2 rst = 1'b1;
    #1 chk("rst clears err", 32'(protocol_err), 32'd0);
    rst = 1'b0;
    apply(mk(0,0,0, 0,0, 1,32'h99, 0,0,0, 1,0,0,0));
    chk("empty resp we",  32'(reg_we),       32'd0);
    chk("empty resp err", 32'(protocol_err), 32'd1);
    idle();
    chk("err sticky",     32'(protocol_err), 32'd1);

    // ---------------- async reset mid-stream with skid HELD and 2 tags ----------------
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    apply(mk(0,0,0, 1,1, 0,0, 0,0,0, 1,0,0,0));
    apply(mk(0,0,0, 1,2, 0,0, 0,0,0, 1,0,0,0));
    apply(mk(0,0,0, 1,3, 0,0, 0,0,0, 1,0,0,0));
    apply(mk(1,5,32'h99, 0,0, 1,32'h31, 0,0,0, 1,0,0,0));
    alu_valid = 0; mem_resp_valid = 0;
    chk("pre-rst we",      32'(reg_we),    32'd1);
    chk("pre-rst waddr",   32'(reg_waddr), 32'd1);
    chk("pre-rst ready",   32'(alu_ready), 32'd0);
    chk("pre-rst pending", pending,        32'h0C);
    #2 rst = 1'b1;
    #1;
    chk("async we",      32'(reg_we),       32'd0);
    chk("async waddr",   32'(reg_waddr),    32'd0);
    chk("async wdata",   reg_wdata,         32'd0);
    chk("async ready",   32'(alu_ready),    32'd1);
    chk("async pending", pending,           32'd0);
    chk("async full",    32'(load_full),    32'd0);
    chk("async err",     32'(protocol_err), 32'd0);
    #1 rst = 1'b0;
    idle();
    chk("after rst we cycle1", 32'(reg_we), 32'd0);
    idle();
    chk("after rst we cycle2", 32'(reg_we), 32'd0);
    chk("after rst pending",   pending,     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
